inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have port in_valid, input, 1 bit: the field bundle is valid.
REQ-004 The block SHALL have port in_ready, output, 1 bit: the encoder can accept a bundle.
REQ-005 The block SHALL have port fmt, input, 3 bits: instruction format; 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
REQ-006 The block SHALL have ports opcode (input, 7 bits), rd (input, 5 bits), rs1 (input, 5 bits), rs2 (input, 5 bits), funct3 (input, 3 bits) and funct7 (input, 7 bits): the raw instruction fields.
REQ-007 The block SHALL have port imm, input, 32 bits: full-width immediate value, two's complement.
REQ-008 The block SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit) and out_inst (output, 32 bits): the encoded instruction stream.
REQ-009 The block SHALL have port out_err, output, 1 bit: the bundle currently at the FIFO head failed the encode check.
REQ-010 The block SHALL have port err_cnt, output, 16 bits: saturating count of accepted bundles that failed the encode check.

Function
REQ-011 A transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; an output transfer SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-012 Encoded results SHALL be held in a 2-entry FIFO; each entry SHALL store {out_inst, out_err}.
REQ-013 in_ready SHALL equal (count<2), where count is the FIFO occupancy; a simultaneous pop SHALL NOT raise in_ready in the same cycle.
REQ-014 Latency SHALL be 1 cycle: a bundle accepted at edge N into an empty FIFO SHALL give out_valid=1 with its result after edge N.
REQ-015 A simultaneous push and pop SHALL leave count unchanged and SHALL preserve order; pop on empty and push on full SHALL be impossible by construction.
REQ-016 opcode SHALL be placed in inst[6:0] for every format.
REQ-017 R format: inst = {funct7, rs2, rs1, funct3, rd, opcode}; imm SHALL be ignored.
REQ-018 I format: inst = {imm[11:0], rs1, funct3, rd, opcode}.
REQ-019 S format: inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-020 B format: inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-021 U format: inst = {imm[31:12], rd, opcode}.
REQ-022 J format: inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-023 For an illegal fmt, out_inst SHALL be 32'h0000_0013 (NOP) and the error SHALL be 1, regardless of configuration.
REQ-024 err_cnt SHALL increment by 1 on every accepted bundle whose error is 1, and SHALL hold at 16'hFFFF once it is reached.

Reset
REQ-025 When rst=1 at an edge, the block SHALL clear count, the FIFO pointers and err_cnt; after that edge out_valid=0, out_err=0, out_inst=0 and in_ready=1.
REQ-026 A reset during traffic SHALL discard all FIFO entries, and in_valid SHALL be ignored on that edge.

Configuration
REQ-027 With macro ENC_RANGE_CHECK_EN defined, the error SHALL be 1 for each of the following conditions: for I/S, imm[31:11] is not all-equal; for B, imm[31:12] is not all-equal or imm[0]=1; for J, imm[31:20] is not all-equal or imm[0]=1; for U, imm[11:0]!=0. The encoding SHALL still follow REQ-018..022.
REQ-028 Without ENC_RANGE_CHECK_EN, excess immediate bits SHALL be silently truncated, and the error SHALL be 1 only for an illegal fmt.

Verification
REQ-029 The bench SHALL cover I-type encode: fmt=1, opcode=7'h13, rd=1, rs1=2, funct3=0, imm=-1 -> out_inst=32'hFFF10093, out_err=0, one cycle after acceptance.
REQ-030 The bench SHALL cover B-type encode: fmt=3, opcode=7'h63, rs1=1, rs2=2, funct3=0, imm=-4 -> out_inst=32'hFE208EE3.
REQ-031 The bench SHALL cover backpressure: 3 back-to-back bundles with out_ready=0 -> in_ready=0 after 2 accepts; then out_ready=1 -> all 3 results emerge in order with no loss.
REQ-032 The bench SHALL cover the range check (macro defined): fmt=1, imm=2048 -> out_err=1 and err_cnt increments by 1; the same stimulus without the macro -> out_err=0 and out_inst[31:20]=12'h800.
REQ-033 The bench SHALL cover illegal fmt=6 -> out_inst=32'h00000013, out_err=1; with err_cnt preloaded to 16'hFFFF by 65535 errors, the next error leaves it at 16'hFFFF.
REQ-034 The bench SHALL cover reset mid-traffic: rst=1 with 2 entries held -> out_valid=0 and in_ready=1 on the next cycle, err_cnt=0.

Source files
------------

// File: rtl/inst_encoder.sv
// inst_encoder: packs raw RISC-V style instruction fields into a 32-bit word
// and queues {inst, err} results in a 2-entry FIFO with valid/ready handshakes
// on both sides. Optional macro ENC_RANGE_CHECK_EN flags immediates that do
// not fit their format; without it, excess immediate bits are truncated.
module inst_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [15:0] err_cnt
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic [31:0] encInst;
  logic        encErr;
  logic        rangeErr;

  logic [32:0] memQ [2];
  logic        wrPtrQ, wrPtrD;
  logic        rdPtrQ, rdPtrD;
  logic [1:0]  countQ, countD;
  logic [15:0] errCntQ, errCntD;

  logic        push;
  logic        pop;

  // Combinational field packing; an unknown format becomes a NOP flagged as an error.
  always_comb begin
    encInst  = NOP_INST;
    encErr   = 1'b0;
    rangeErr = 1'b0;
    case (fmt)
      FMT_R: encInst = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        encInst = {imm[11:0], rs1, funct3, rd, opcode};
`ifdef ENC_RANGE_CHECK_EN
        rangeErr = !((&imm[31:11]) || !(|imm[31:11]));
`endif
      end
      FMT_S: begin
        encInst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
`ifdef ENC_RANGE_CHECK_EN
        rangeErr = !((&imm[31:11]) || !(|imm[31:11]));
`endif
      end
      FMT_B: begin
        encInst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
`ifdef ENC_RANGE_CHECK_EN
        rangeErr = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
`endif
      end
      FMT_U: begin
        encInst = {imm[31:12], rd, opcode};
`ifdef ENC_RANGE_CHECK_EN
        rangeErr = |imm[11:0];
`endif
      end
      FMT_J: begin
        encInst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
`ifdef ENC_RANGE_CHECK_EN
        rangeErr = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
`endif
      end
      default: begin
        encInst = NOP_INST;
        encErr  = 1'b1;
      end
    endcase
    if (rangeErr) begin
      encErr = 1'b1;
    end
  end

  // Handshake decode; in_ready comes from registered occupancy so a same-cycle pop never raises it.
  always_comb begin
    in_ready  = (countQ < 2'd2);
    out_valid = (countQ != 2'd0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    out_inst  = out_valid ? memQ[rdPtrQ][32:1] : 32'h0;
    out_err   = out_valid ? memQ[rdPtrQ][0] : 1'b0;
    err_cnt   = errCntQ;
  end

  // Next-state for pointers, occupancy and the saturating error counter.
  always_comb begin
    wrPtrD  = push ? ~wrPtrQ : wrPtrQ;
    rdPtrD  = pop ? ~rdPtrQ : rdPtrQ;
    countD  = countQ + {1'b0, push} - {1'b0, pop};
    errCntD = errCntQ;
    if (push && encErr && (errCntQ != 16'hFFFF)) begin
      errCntD = errCntQ + 16'd1;
    end
  end

  // Control state register; reset empties the FIFO and drops any bundle offered on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtrQ  <= 1'b0;
      rdPtrQ  <= 1'b0;
      countQ  <= 2'd0;
      errCntQ <= 16'h0;
    end else begin
      wrPtrQ  <= wrPtrD;
      rdPtrQ  <= rdPtrD;
      countQ  <= countD;
      errCntQ <= errCntD;
    end
  end

  // FIFO storage needs no reset because outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      memQ[wrPtrQ] <= {encInst, encErr};
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Testbench for inst_encoder: randomized traffic scored against a queue-based
// model, plus directed literal checks of known encodings and corner cases.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] err_cnt;

  int total = 0;
  int bad   = 0;

  logic [32:0] mq[$];
  logic [15:0] mErr = 16'h0;
  bit          checkEn = 1'b0;

  inst_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .err_cnt(err_cnt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference encoding built from field weights and signed immediate ranges.
  function automatic logic [32:0] modelEncode(input logic [2:0] f, input logic [6:0] op,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
    logic [31:0] w;
    logic        e;
    int          s;
    s = $signed(im);
    e = 1'b0;
    w = 32'(op) + (32'(f3) << 12) + (32'(s1) << 15) + (32'(s2) << 20);
    case (f)
      3'd0: w = w + (32'(d) << 7) + (32'(f7) << 25);
      3'd1: begin
        w = 32'(op) + (32'(d) << 7) + (32'(f3) << 12) + (32'(s1) << 15) + ((im & 32'hFFF) << 20);
        e = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        w = w + ((im & 32'h1F) << 7) + (((im >> 5) & 32'h7F) << 25);
        e = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        w = w + (((im >> 11) & 32'h1) << 7) + (((im >> 1) & 32'hF) << 8)
              + (((im >> 5) & 32'h3F) << 25) + (((im >> 12) & 32'h1) << 31);
        e = (s < -4096) || (s > 4095) || ((im % 2) != 0);
      end
      3'd4: begin
        w = (im & 32'hFFFF_F000) + (32'(d) << 7) + 32'(op);
        e = (im % 4096) != 0;
      end
      3'd5: begin
        w = 32'(op) + (32'(d) << 7) + (((im >> 12) & 32'hFF) << 12) + (((im >> 11) & 32'h1) << 20)
          + (((im >> 1) & 32'h3FF) << 21) + (((im >> 20) & 32'h1) << 31);
        e = (s < -1048576) || (s > 1048575) || ((im % 2) != 0);
      end
      default: begin
        return {32'h0000_0013, 1'b1};
      end
    endcase
`ifndef ENC_RANGE_CHECK_EN
    e = 1'b0;
`endif
    return {w, e};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] im);
    in_valid = 1'b1;
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
  endtask

  // Behavioural model: FIFO of expected results and saturating error count.
  always @(posedge clk) begin
    logic        acc;
    logic        pp;
    logic [32:0] r;
    if (rst) begin
      mq.delete();
      mErr = 16'h0;
    end else begin
      acc = in_valid && (mq.size() < 2);
      pp  = out_ready && (mq.size() > 0);
      r   = modelEncode(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
      if (pp) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(r);
        if (r[0] && mErr != 16'hFFFF) mErr = mErr + 16'd1;
      end
    end
  end

  // Compare DUT outputs with the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("in_ready", 32'(in_ready), 32'(mq.size() < 2));
      checkOutput("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        checkOutput("out_inst", out_inst, mq[0][32:1]);
        checkOutput("out_err", 32'(out_err), 32'(mq[0][0]));
      end else begin
        checkOutput("out_inst_idle", out_inst, 32'h0);
        checkOutput("out_err_idle", 32'(out_err), 32'h0);
      end
      checkOutput("err_cnt", 32'(err_cnt), 32'(mErr));
    end
  end

  initial begin
    logic [31:0] got [3];
    logic [31:0] expU [3];
    int          n;
    logic        acc;
    logic [15:0] prevCnt;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    fmt = 3'd0; opcode = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0;
    step();
    checkEn = 1'b1;
    step();
    rst = 1'b0;

    // Reset state.
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_out_inst", out_inst, 32'h0);
    checkOutput("rst_out_err", 32'(out_err), 32'h0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'h0);

    // I-type encode, one cycle after acceptance.
    applyStimulus(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    step();
    in_valid = 1'b0;
    checkOutput("itype_valid", 32'(out_valid), 32'h1);
    checkOutput("itype_inst", out_inst, 32'hFFF1_0093);
    checkOutput("itype_err", 32'(out_err), 32'h0);
    drain();

    // B-type encode.
    out_ready = 1'b0;
    applyStimulus(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
    step();
    in_valid = 1'b0;
    checkOutput("btype_inst", out_inst, 32'hFE20_8EE3);
    checkOutput("btype_err", 32'(out_err), 32'h0);
    drain();

    // Backpressure: three U-type bundles with the output stalled.
    expU[0] = 32'h0000_10B7; expU[1] = 32'h0000_2137; expU[2] = 32'h0000_31B7;
    out_ready = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      applyStimulus(3'd4, 7'h37, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k) << 12);
      step();
    end
    applyStimulus(3'd4, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h3000);
    checkOutput("bp_in_ready_full", 32'(in_ready), 32'h0);
    step();
    checkOutput("bp_still_full", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      if (out_valid) begin
        got[n] = out_inst;
        n++;
      end
      acc = in_valid && in_ready;
      step();
      if (acc) in_valid = 1'b0;
    end
    checkOutput("bp_count", 32'(n), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < n) checkOutput("bp_order", got[k], expU[k]);
    end
    drain();

    // Immediate 2048 on I-type: in range only when the check is disabled.
    out_ready = 1'b0;
    prevCnt = err_cnt;
    applyStimulus(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048);
    step();
    in_valid = 1'b0;
    checkOutput("range_imm_field", 32'(out_inst[31:20]), 32'h800);
`ifdef ENC_RANGE_CHECK_EN
    checkOutput("range_err", 32'(out_err), 32'h1);
    checkOutput("range_cnt", 32'(err_cnt), 32'(prevCnt + 16'd1));
`else
    checkOutput("range_err", 32'(out_err), 32'h0);
    checkOutput("range_cnt", 32'(err_cnt), 32'(prevCnt));
`endif
    drain();

    // Illegal format becomes a flagged NOP.
    out_ready = 1'b0;
    applyStimulus(3'd6, 7'h33, 5'd7, 5'd8, 5'd9, 3'd1, 7'd2, 32'h1234);
    step();
    in_valid = 1'b0;
    checkOutput("illegal_inst", out_inst, 32'h0000_0013);
    checkOutput("illegal_err", 32'(out_err), 32'h1);
    drain();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] im;
      case ($urandom_range(0, 3))
        0: im = $urandom;
        1: im = 32'($signed($urandom_range(0, 4095)) - 2048);
        2: im = 32'($signed($urandom_range(0, 8191)) - 4096) & 32'hFFFF_FFFE;
        default: im = $urandom & 32'hFFFF_F000;
      endcase
      applyStimulus(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                    5'($urandom), 3'($urandom), 7'($urandom), im);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    drain();

    // Reset mid-traffic with two entries held.
    out_ready = 1'b0;
    applyStimulus(3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    step();
    step();
    checkOutput("mid_full", 32'(in_ready), 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    checkOutput("mid_out_valid", 32'(out_valid), 32'h0);
    checkOutput("mid_in_ready", 32'(in_ready), 32'h1);
    checkOutput("mid_err_cnt", 32'(err_cnt), 32'h0);

    // Saturation: 65535 errors reach FFFF and the next one holds there.
    out_ready = 1'b1;
    applyStimulus(3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    repeat (65534) step();
    checkOutput("sat_fffe", 32'(err_cnt), 32'hFFFE);
    step();
    checkOutput("sat_ffff", 32'(err_cnt), 32'hFFFF);
    step();
    checkOutput("sat_hold", 32'(err_cnt), 32'hFFFF);
    checkOutput("sat_illegal_err", 32'(out_err), 32'h1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
